// File: rtl/pe_array_cfg_sequencer.sv
// Configuration/run sequencer for a row of PEs: streams host instruction words
// into each PE's config buffer (PE-major order), then drives a timed run strobe.
module pe_array_cfg_sequencer #(
  parameter int NUM_PE = 16,
  parameter int INST_W = 48,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 6,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst_data,
  output logic              inst_ready,
  output logic [INST_W-1:0] pe_inst,
  output logic [NUM_PE-1:0] pe_init,
  output logic              pe_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_ctx_idx;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_run_cnt;
  logic [PE_W-1:0]   r_pe_idx;
  logic [INST_W-1:0] r_pe_inst;
  logic [NUM_PE-1:0] r_pe_init;
  logic              r_pe_run;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_cmd_ok;
  logic              w_accept;
  logic              w_last_ctx;
  logic              w_last_pe;
  logic              w_run_end;
  logic              w_err_next;
  logic [NUM_PE-1:0] w_onehot;

  assign w_cmd_ok   = (int'(cfg_len) != 0) && (int'(cfg_len) <= DEPTH) &&
                      (int'(run_cycles) <= int'(cfg_len));
  assign w_accept   = (r_state == S_LOAD) && inst_valid;
  assign w_last_ctx = (r_ctx_idx == (r_len - LEN_W'(1)));
  assign w_last_pe  = (r_pe_idx == PE_W'(NUM_PE - 1));
  assign w_run_end  = (r_run_cnt == r_cyc);
  assign w_err_next = cfg_start && ((r_state != S_IDLE) || !w_cmd_ok);

  always_comb begin
    w_onehot           = '0;
    w_onehot[r_pe_idx] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    inst_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start && w_cmd_ok) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        inst_ready = 1'b1;
        if (w_accept && w_last_ctx && w_last_pe) w_state_next = S_RUN;
      end
      S_RUN: begin
        // run_cnt reaching cyc_r covers cyc_r==0: DONE on the first RUN edge
        if (w_run_end) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cyc     <= '0;
      r_ctx_idx <= '0;
      r_pe_idx  <= '0;
      r_run_cnt <= '0;
      r_pe_inst <= '0;
      r_pe_init <= '0;
      r_pe_run  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_err     <= w_err_next;
      r_busy    <= (w_state_next == S_LOAD) || (w_state_next == S_RUN);
      r_done    <= (w_state_next == S_DONE);
      r_pe_init <= w_accept ? w_onehot : '0;
      r_pe_run  <= (r_state == S_RUN) && !w_run_end;

      if ((r_state == S_IDLE) && cfg_start && w_cmd_ok) begin
        r_len <= cfg_len;
        r_cyc <= run_cycles;
      end

      if (w_accept) begin
        r_pe_inst <= inst_data;
        if (w_last_ctx) begin
          r_ctx_idx <= '0;
          r_pe_idx  <= r_pe_idx + PE_W'(1);
        end else begin
          r_ctx_idx <= r_ctx_idx + LEN_W'(1);
        end
      end

      if ((r_state == S_RUN) && !w_run_end) r_run_cnt <= r_run_cnt + CNT_W'(1);
    end
  end

  assign pe_inst = r_pe_inst;
  assign pe_init = r_pe_init;
  assign pe_run  = r_pe_run;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_pe_array_cfg_sequencer.sv
// Directed + randomized bench for pe_array_cfg_sequencer; expected strobes are
// derived from word index arithmetic (word i -> PE i/len) and cycle counts.
module tb_pe_array_cfg_sequencer;

  localparam int NUM_PE = 16;
  localparam int INST_W = 48;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 6;
  localparam int CNT_W  = 6;

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic [LEN_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  run_cycles;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic              inst_ready;
  logic [INST_W-1:0] pe_inst;
  logic [NUM_PE-1:0] pe_init;
  logic              pe_run;
  logic              busy;
  logic              done;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  pe_array_cfg_sequencer #(
    .NUM_PE(NUM_PE),
    .INST_W(INST_W),
    .DEPTH (DEPTH),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_len   (cfg_len),
    .run_cycles(run_cycles),
    .inst_valid(inst_valid),
    .inst_data (inst_data),
    .inst_ready(inst_ready),
    .pe_inst   (pe_inst),
    .pe_init   (pe_init),
    .pe_run    (pe_run),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(inst_ready), 64'd0);
    chk({tag, "_inst"},  64'(pe_inst),    64'd0);
    chk({tag, "_init"},  64'(pe_init),    64'd0);
    chk({tag, "_run"},   64'(pe_run),     64'd0);
    chk({tag, "_busy"},  64'(busy),       64'd0);
    chk({tag, "_done"},  64'(done),       64'd0);
    chk({tag, "_err"},   64'(err),        64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
  endtask

  task automatic start_cmd(input int len, input int cyc);
    cfg_start  = 1'b1;
    cfg_len    = LEN_W'(len);
    run_cycles = CNT_W'(cyc);
    tick();
    cfg_start  = 1'b0;
  endtask

  task automatic illegal_cmd(input string tag, input int len, input int cyc);
    start_cmd(len, cyc);
    chk({tag, "_err"},   64'(err),        64'd1);
    chk({tag, "_busy"},  64'(busy),       64'd0);
    chk({tag, "_ready"}, 64'(inst_ready), 64'd0);
    tick();
    chk({tag, "_err_clr"},  64'(err),        64'd0);
    chk({tag, "_idle"},     64'(inst_ready), 64'd0);
  endtask

  // Loads NUM_PE*len words, then checks the run window. midstart_at/rst_at are
  // word indices at which to inject a cfg_start or a reset (-1 = never).
  task automatic do_program(input int len, input int cyc, input int valid_pct,
                            input bit seq_data, input int midstart_at, input int rst_at);
    logic [INST_W-1:0] words[$];
    logic [NUM_PE-1:0] exp_init;
    int total;
    int sent;
    int iter;
    bit v;
    bit pulsed;
    bit mid_used;
    total    = NUM_PE * len;
    mid_used = 1'b0;
    for (int i = 0; i < total; i++)
      words.push_back(seq_data ? INST_W'(i) : {$urandom, $urandom});
    start_cmd(len, cyc);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_err",  64'(err),  64'd0);
    sent = 0;
    iter = 0;
    while (sent < total) begin
      if (iter > 4000) begin
        chk("load_timeout", 64'(sent), 64'(total));
        break;
      end
      iter++;
      chk("load_ready", 64'(inst_ready), 64'd1);
      v          = ($urandom_range(99) < valid_pct);
      inst_valid = v;
      inst_data  = words[sent];
      pulsed     = 1'b0;
      if (sent == midstart_at && !mid_used) begin
        cfg_start  = 1'b1;
        cfg_len    = LEN_W'(1);
        run_cycles = CNT_W'(0);
        pulsed     = 1'b1;
        mid_used   = 1'b1;
      end
      if (sent == rst_at) begin
        rst = 1'b0;
        tick();
        check_reset_vals("midrst");
        rst        = 1'b1;
        inst_valid = 1'b0;
        cfg_start  = 1'b0;
        return;
      end
      tick();
      cfg_start = 1'b0;
      chk("load_err_pulse", 64'(err), 64'(pulsed));
      if (v) begin
        exp_init = '0;
        exp_init[sent / len] = 1'b1;
        chk("init_onehot", 64'(pe_init), 64'(exp_init));
        chk("init_data",   64'(pe_inst), 64'(words[sent]));
        sent++;
      end else begin
        chk("init_idle", 64'(pe_init), 64'd0);
      end
      chk("load_no_run", 64'(pe_run), 64'd0);
    end
    inst_valid = 1'b0;
    for (int c = 0; c < cyc; c++) begin
      tick();
      chk("run_strobe", 64'(pe_run),     64'd1);
      chk("run_noinit", 64'(pe_init),    64'd0);
      chk("run_busy",   64'(busy),       64'd1);
      chk("run_ready",  64'(inst_ready), 64'd0);
    end
    tick();
    chk("end_run",  64'(pe_run), 64'd0);
    chk("end_done", 64'(done),   64'd1);
    chk("end_busy", 64'(busy),   64'd0);
  endtask

  initial begin
    int len;
    rst        = 1'b0;
    cfg_start  = 1'b0;
    cfg_len    = '0;
    run_cycles = '0;
    inst_valid = 1'b0;
    inst_data  = '0;
    tick();
    tick();
    check_reset_vals("por");
    rst = 1'b1;
    tick();

    illegal_cmd("ill_len0",  0, 0);
    illegal_cmd("ill_len33", 33, 0);
    illegal_cmd("ill_cyc",   3, 4);

    // Basic: sequential data, valid held high, then sticky done
    do_program(2, 2, 100, 1'b1, -1, -1);
    start_cmd(1, 1);
    chk("sticky_err",  64'(err),  64'd1);
    chk("sticky_done", 64'(done), 64'd1);
    chk("sticky_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sticky_hold", 64'(done), 64'd1);
      chk("sticky_err0", 64'(err),  64'd0);
    end
    do_reset();

    // Backpressure with random geometry
    len = $urandom_range(4, 1);
    do_program(len, $urandom_range(len, 0), 55, 1'b0, -1, -1);
    do_reset();

    // Zero-length run
    do_program(1, 0, 100, 1'b0, -1, -1);
    do_reset();

    // Mid-load cfg_start, then reset at word 7, then a fresh program
    do_program(2, 1, 80, 1'b0, 3, 7);
    tick();
    check_reset_vals("post_rst");
    do_program(3, 3, 70, 1'b0, -1, -1);
    do_reset();

    // Full-depth boundary
    do_program(DEPTH, DEPTH, 90, 1'b0, -1, -1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
